// File: rtl/hex_display_ctrl.sv
// Registered seven-segment controller for DIGITS hex digits: capture on load,
// glyph decode with leading-zero suppression, per-digit blink, lamp test and scan bus.
module hex_display_ctrl #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lz_en,
    input  logic                  lamp_test,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   blink_r;
    logic                lz_r;
    logic                blink_phase;
    logic [BW-1:0]       bcnt;
    logic [SW-1:0]       scnt;
    logic [IW-1:0]       idx;

    logic [7*DIGITS-1:0] hex_next;
    logic [DIGITS-1:0]   suppress;
    logic                higher_zero;
    logic [3:0]          nib;
    logic [IW-1:0]       idx_next;
    logic [DIGITS-1:0]   sel_next;
    logic                scan_wrap;
    logic                blink_wrap;
    logic [6:0]          hex_dig [DIGITS];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        higher_zero = 1'b1;
        suppress    = '0;
        nib         = '0;
        // Walk from the most significant digit down; digit 0 is never blanked.
        for (int unsigned k = 0; k < DIGITS; k++) begin
            nib         = value_r[4*(DIGITS-1-k) +: 4];
            higher_zero = higher_zero & (nib == 4'h0);
            suppress[DIGITS-1-k] = lz_r & higher_zero & (k != DIGITS-1);
        end

        hex_next = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (lamp_test)
                hex_next[7*i +: 7] = 7'h00;
            else if (blink_phase && blink_r[i])
                hex_next[7*i +: 7] = 7'h7F;
            else if (suppress[i])
                hex_next[7*i +: 7] = 7'h7F;
            else
                hex_next[7*i +: 7] = glyph(value_r[4*i +: 4]);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++)
            hex_dig[i] = hex_out[7*i +: 7];

        blink_wrap = (bcnt == BW'(BLINK_DIV - 1));
        scan_wrap  = (scnt == SW'(SCAN_DIV - 1));
        idx_next   = idx;
        if (scan_wrap)
            idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        sel_next           = '1;
        sel_next[idx_next] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_r     <= '0;
            blink_r     <= '0;
            lz_r        <= 1'b0;
            blink_phase <= 1'b0;
            bcnt        <= '0;
            scnt        <= '0;
            idx         <= '0;
            hex_out     <= '1;
            seg_mux     <= '1;
            dig_sel     <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            if (load) begin
                value_r <= value_in;
                blink_r <= blink_en;
                lz_r    <= lz_en;
            end
            bcnt <= blink_wrap ? '0 : bcnt + 1'b1;
            if (blink_wrap)
                blink_phase <= ~blink_phase;
            scnt    <= scan_wrap ? '0 : scnt + 1'b1;
            idx     <= idx_next;
            hex_out <= hex_next;
            // Selected slice comes from the current register, so seg_mux trails hex_out by a cycle.
            seg_mux <= hex_dig[idx_next];
            dig_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with DIGITS=4, BLINK_DIV=4, SCAN_DIV=2.
module tb_hex_display_ctrl;

    logic        clock;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  blink_en;
    logic        lz_en;
    logic        lamp_test;
    logic [27:0] hex_out;
    logic [6:0]  seg_mux;
    logic [3:0]  dig_sel;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] dg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    hex_display_ctrl #(
        .DIGITS(4),
        .BLINK_DIV(4),
        .SCAN_DIV(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .value_in(value_in),
        .load(load),
        .blink_en(blink_en),
        .lz_en(lz_en),
        .lamp_test(lamp_test),
        .hex_out(hex_out),
        .seg_mux(seg_mux),
        .dig_sel(dig_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since the reset edge: blink phase and scan index follow directly from it.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        logic [6:0] exp0;
        logic [3:0] expsel;
        int idx;
        int guard;

        reset = 1'b1; value_in = '0; load = 1'b0; blink_en = '0; lz_en = 1'b0; lamp_test = 1'b0;
        step();
        check("rst_hex", hex_out, {4{7'h7F}});
        check("rst_seg", seg_mux, 7'h7F);
        check("rst_sel", dig_sel, 4'b1110);

        reset = 1'b0;
        step();
        check("first_edge", hex_out, {4{7'h40}});

        value_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        check("load_lat", hex_out, {4{7'h40}});
        step();
        check("load_1234", hex_out, pack4(7'h79, 7'h24, 7'h30, 7'h19));

        for (int n = 0; n < 16; n++) begin
            value_in = 16'(n); load = 1'b1;
            step();
            load = 1'b0;
            step();
            check("sweep", hex_out, pack4(7'h40, 7'h40, 7'h40, gl[n]));
        end

        lz_en = 1'b1;
        value_in = 16'h0050; load = 1'b1; step(); load = 1'b0; step();
        check("lz_0050", hex_out, pack4(7'h7F, 7'h7F, 7'h12, 7'h40));
        value_in = 16'h0000; load = 1'b1; step(); load = 1'b0; step();
        check("lz_0000", hex_out, pack4(7'h7F, 7'h7F, 7'h7F, 7'h40));
        value_in = 16'h0100; load = 1'b1; step(); load = 1'b0; step();
        check("lz_0100", hex_out, pack4(7'h7F, 7'h79, 7'h40, 7'h40));

        lz_en = 1'b0; blink_en = 4'b0001;
        value_in = 16'hABCD; load = 1'b1; step(); load = 1'b0; step();
        for (int k = 0; k < 16; k++) begin
            exp0 = ((((cyc - 1) / 4) % 2) == 1) ? 7'h7F : 7'h21;
            check("blink", hex_out, pack4(7'h08, 7'h03, 7'h46, exp0));
            step();
        end

        guard = 0;
        while (((cyc / 4) % 2) != 1 && guard < 20) begin
            step();
            guard++;
        end
        check("lamp_wait", guard < 20, 1);
        lamp_test = 1'b1;
        step();
        check("lamp_on", hex_out, 28'h0);
        lamp_test = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            exp0 = ((((cyc - 1) / 4) % 2) == 1) ? 7'h7F : 7'h21;
            check("lamp_resume", hex_out, pack4(7'h08, 7'h03, 7'h46, exp0));
        end

        reset = 1'b1; blink_en = '0;
        step();
        reset = 1'b0;
        value_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            idx = (cyc / 2) % 4;
            expsel = ~(4'b0001 << idx);
            check("scan_sel", dig_sel, expsel);
            check("scan_seg", seg_mux, dg1234[idx]);
            step();
        end

        guard = 0;
        while (((cyc / 2) % 4) != 2 && guard < 20) begin
            step();
            guard++;
        end
        check("scan_wait", guard < 20, 1);
        reset = 1'b1; load = 1'b1; value_in = 16'hFFFF;
        step();
        check("midrst_sel", dig_sel, 4'b1110);
        check("midrst_hex", hex_out, {4{7'h7F}});
        check("midrst_seg", seg_mux, 7'h7F);
        reset = 1'b0; load = 1'b0;
        step();
        check("rst_load_drop", hex_out, {4{7'h40}});
        check("rescan_0", dig_sel, 4'b1110);
        step();
        check("rescan_1", dig_sel, 4'b1101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

- Registered, parametrised seven-segment display controller for DIGITS hex digits.
- Captures a packed hex value on a load strobe and decodes each nibble to an active-low segment pattern.
- Adds leading-zero suppression, per-digit blink, lamp test and a time-multiplexed scan output.
- Sits between datapath registers and the board HEX displays: parallel outputs drive HEX0..HEXn directly; the scan bus serves multiplexed modules.

## Interface
- DIGITS, 4: number of digits, legal 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period, ≥2.
- SCAN_DIV, 50000: clock cycles each digit is selected on the scan bus, ≥1.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; wins over every other input.
- value_in  in  4*DIGITS  packed nibbles; digit i = value_in[4i+3:4i], digit 0 least significant.
- load  in  1  capture strobe for value_in, blink_en, lz_en.
- blink_en  in  DIGITS  per-digit blink enable; captured on load.
- lz_en  in  1  leading-zero suppression enable; captured on load.
- lamp_test  in  1  level; forces all segments on.
- hex_out  out  7*DIGITS  registered parallel segments; digit i = hex_out[7i+6:7i], bit0=a … bit6=g, active-low.
- seg_mux  out  7  registered segments of the currently scanned digit.
- dig_sel  out  DIGITS  registered active-low one-hot digit select.

## Operation
- Glyphs, 7-bit, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank=7F; lamp test=00.
- Capture registers: value_r, blink_r, lz_r are loaded when load=1; otherwise they hold. load may be asserted on any cycle, including back-to-back; no handshake.
- Leading-zero suppression (when lz_r=1):
  - Starting at digit DIGITS-1 and moving down, a digit is suppressed while it and every higher digit are 0.
  - Digit 0 is never suppressed, so value 0 shows "0" on digit 0 only.
- Blink prescaler:
  - Free-running counter 0..BLINK_DIV-1, unaffected by load.
  - On wrap it toggles blink_phase.
  - When blink_phase=1, digits with blink_r[i]=1 are blanked.
- Per-digit priority when computing the next hex_out: lamp_test (00) > blink blank (7F) > leading-zero blank (7F) > glyph.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap, scan index advances i → i+1, wrapping DIGITS-1 → 0.
  - dig_sel has bit idx low, all others high.
  - seg_mux = hex_out slice idx; dig_sel and seg_mux update on the same edge.
- DIGITS=1: scan index stays 0 and dig_sel stays 0.
- Counter widths are $clog2 of the divisor, minimum 1 bit.

## Timing
- Reset state (next edge after reset=1):
  - value_r=0, blink_r=0, lz_r=0, blink_phase=0.
  - Both prescalers 0, scan index 0.
  - hex_out all 7F, seg_mux=7F, dig_sel = all ones except bit0=0.
- First edge after reset release: hex_out becomes all 40.
- Load latency: load sampled at edge N → value_r updated at N → hex_out shows the new value at edge N+1.
- lamp_test latency: lamp_test sampled at edge N → hex_out reflects it at edge N.
- seg_mux lags hex_out by one cycle.
- Blink period is exactly 2*BLINK_DIV cycles: phase toggles on the edge where the prescaler wraps from BLINK_DIV-1.
- Each digit is selected for exactly SCAN_DIV cycles.
- Simultaneous events:
  - reset with load: reset wins and the load is discarded.
  - load while blinking: blink phase continues uninterrupted.
  - lamp_test with anything else: lamp test wins.
- Reset mid-scan or mid-blink: both prescalers and the index return to 0 on that edge.

## Test plan
Bench parameters: DIGITS=4, BLINK_DIV=4, SCAN_DIV=2.
- Reset, then load 16'h1234 → two edges later hex_out digits 3..0 = 79, 24, 30, 19.
- Sweep value_in[3:0] over 0..F with one load each → digit 0 matches the glyph table exactly; digits 1..3 = 40.
- lz_en=1, load 16'h0050 → digits 3..0 = 7F, 7F, 12, 40; then load 16'h0000 → 7F, 7F, 7F, 40.
- blink_en=4'b0001, load 16'hABCD → digit 0 alternates 21 / 7F every 4 cycles; digits 3..1 hold 08, 03, 46.
- Assert lamp_test during a blank blink phase → all digits 00; deassert → blink pattern resumes in the correct phase.
- Scan check:
  - dig_sel cycles 1110 → 1101 → 1011 → 0111, each held 2 cycles, with seg_mux equal to the matching hex_out slice one cycle late.
  - Assert reset mid-scan → next edge dig_sel=1110, hex_out all 7F.
